// File: rtl/eth_udp_tx_framer.sv
// Ethernet II / IPv4 / UDP transmit framer: streams header, payload and zero padding
// as bytes with a valid/ready handshake; no preamble or FCS.
module eth_udp_tx_framer #(
  parameter int unsigned BUF_SIZE = 1024,
  parameter logic [7:0]  IP_TTL   = 8'h40
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [47:0]         i_self_mac,
  input  logic [47:0]         i_dest_mac,
  input  logic [31:0]         i_self_ip,
  input  logic [31:0]         i_dest_ip,
  input  logic [15:0]         i_src_port,
  input  logic [15:0]         i_dest_port,
  input  logic [15:0]         i_length,
  input  logic [BUF_SIZE-1:0] i_buf,
  output logic [7:0]          o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_len_err
);

  localparam int unsigned BUF_BYTES = BUF_SIZE / 8;
  localparam int unsigned PW        = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
  localparam int unsigned HDR_BYTES = 42;

  typedef enum logic [2:0] {IDLE, CSUM1, CSUM2, HDR, PAYLOAD, PAD} state_t;

  state_t       state_q, state_d;
  logic [47:0]  self_mac_q, dest_mac_q;
  logic [31:0]  self_ip_q, dest_ip_q;
  logic [15:0]  src_port_q, dest_port_q, len_q;
  logic [15:0]  ip_id_q, ip_id_d;
  logic [31:0]  sum_q, sum_d;
  logic [15:0]  csum_q, csum_d;
  logic [15:0]  idx_q, idx_d;
  logic [7:0]   data_d;
  logic         valid_d, last_d, busy_d, done_d, len_err_d, latch;

  logic [15:0]  total_len, udp_len, frame_last, pay_end, sel_idx;
  logic [16:0]  fold1;
  logic [15:0]  fold2;
  logic [335:0] hdr_vec;
  logic [7:0]   hdr_bytes [64];
  logic [7:0]   buf_bytes [BUF_BYTES];
  logic [7:0]   sel_byte;
  state_t       sel_state;

  assign total_len  = 16'd28 + len_q;
  assign udp_len    = 16'd8 + len_q;
  assign pay_end    = len_q + 16'(HDR_BYTES);
  assign frame_last = (len_q < 16'd18) ? 16'd59 : len_q + 16'd41;

  // ones-complement fold: after the first fold the value is at most 1FFFE, so one more add fits
  assign fold1 = 17'(sum_q[15:0]) + 17'(sum_q[31:16]);
  assign fold2 = fold1[15:0] + 16'(fold1[16]);

  assign hdr_vec = {dest_mac_q, self_mac_q, 16'h0800,
                    16'h4500, total_len, ip_id_q, 16'h4000, IP_TTL, 8'h11, csum_q,
                    self_ip_q, dest_ip_q,
                    src_port_q, dest_port_q, udp_len, 16'h0000};

  for (genvar g = 0; g < 64; g++) begin : g_hdr
    if (g < HDR_BYTES) begin : g_on
      assign hdr_bytes[g] = hdr_vec[335 - 8*g -: 8];
    end else begin : g_off
      assign hdr_bytes[g] = 8'h00;
    end
  end

  for (genvar g = 0; g < BUF_BYTES; g++) begin : g_buf
    assign buf_bytes[g] = i_buf[8*g +: 8];
  end

  // byte to present next: frame byte 0 when leaving CSUM2, otherwise the one after the current
  always_comb begin
    sel_idx   = (state_q == CSUM2) ? 16'd0 : idx_q + 16'd1;
    sel_byte  = 8'h00;
    sel_state = PAD;
    if (sel_idx < 16'(HDR_BYTES)) begin
      sel_byte  = hdr_bytes[6'(sel_idx)];
      sel_state = HDR;
    end else if (sel_idx < pay_end) begin
      sel_byte  = buf_bytes[PW'(sel_idx - 16'(HDR_BYTES))];
      sel_state = PAYLOAD;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = o_data;
    valid_d   = o_valid;
    last_d    = o_last;
    busy_d    = o_busy;
    done_d    = 1'b0;
    len_err_d = 1'b0;
    ip_id_d   = ip_id_q;
    sum_d     = sum_q;
    csum_d    = csum_q;
    latch     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_length <= 16'(BUF_BYTES)) begin
            latch   = 1'b1;
            busy_d  = 1'b1;
            state_d = CSUM1;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      CSUM1: begin
        sum_d = 32'h4500 + 32'(total_len) + 32'(ip_id_q) + 32'h4000 + 32'({IP_TTL, 8'h11})
              + 32'(self_ip_q[31:16]) + 32'(self_ip_q[15:0])
              + 32'(dest_ip_q[31:16]) + 32'(dest_ip_q[15:0]);
        state_d = CSUM2;
      end
      CSUM2: begin
        csum_d  = ~fold2;
        idx_d   = 16'd0;
        data_d  = sel_byte;
        valid_d = 1'b1;
        last_d  = 1'b0;
        state_d = HDR;
      end
      HDR, PAYLOAD, PAD: begin
        if (i_ready) begin
          if (o_last) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ip_id_d = ip_id_q + 16'd1;
            state_d = IDLE;
          end else begin
            idx_d   = sel_idx;
            data_d  = sel_byte;
            last_d  = (sel_idx == frame_last);
            state_d = sel_state;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_len_err   <= 1'b0;
      ip_id_q     <= '0;
      sum_q       <= '0;
      csum_q      <= '0;
      self_mac_q  <= '0;
      dest_mac_q  <= '0;
      self_ip_q   <= '0;
      dest_ip_q   <= '0;
      src_port_q  <= '0;
      dest_port_q <= '0;
      len_q       <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      o_data    <= data_d;
      o_valid   <= valid_d;
      o_last    <= last_d;
      o_busy    <= busy_d;
      o_done    <= done_d;
      o_len_err <= len_err_d;
      ip_id_q   <= ip_id_d;
      sum_q     <= sum_d;
      csum_q    <= csum_d;
      if (latch) begin
        self_mac_q  <= i_self_mac;
        dest_mac_q  <= i_dest_mac;
        self_ip_q   <= i_self_ip;
        dest_ip_q   <= i_dest_ip;
        src_port_q  <= i_src_port;
        dest_port_q <= i_dest_port;
        len_q       <= i_length;
      end
    end
  end

endmodule

// File: tb/tb_eth_udp_tx_framer.sv
// Scoreboard bench for eth_udp_tx_framer: expected frame bytes are queued at start
// and compared as the DUT hands them over.
module tb_eth_udp_tx_framer;

  localparam int unsigned BUF_SIZE  = 1024;
  localparam int unsigned BUF_BYTES = BUF_SIZE / 8;
  localparam logic [7:0]  TTL       = 8'h40;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic                i_clk = 1'b0;
  logic                i_rstn = 1'b0;
  logic                i_start = 1'b0;
  logic [47:0]         i_self_mac = '0;
  logic [47:0]         i_dest_mac = '0;
  logic [31:0]         i_self_ip = '0;
  logic [31:0]         i_dest_ip = '0;
  logic [15:0]         i_src_port = '0;
  logic [15:0]         i_dest_port = '0;
  logic [15:0]         i_length = '0;
  logic [BUF_SIZE-1:0] i_buf = '0;
  logic                i_ready = 1'b1;
  logic [7:0]          o_data;
  logic                o_valid, o_last, o_busy, o_done, o_len_err;

  eth_udp_tx_framer #(.BUF_SIZE(BUF_SIZE), .IP_TTL(TTL)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_start    (i_start),
    .i_self_mac (i_self_mac),
    .i_dest_mac (i_dest_mac),
    .i_self_ip  (i_self_ip),
    .i_dest_ip  (i_dest_ip),
    .i_src_port (i_src_port),
    .i_dest_port(i_dest_port),
    .i_length   (i_length),
    .i_buf      (i_buf),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_last     (o_last),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_len_err  (o_len_err)
  );

  always #5 i_clk = ~i_clk;

  int         vectors = 0;
  int         miscompares = 0;
  exp_t       exp_q[$];
  logic [7:0] tb_bytes [0:BUF_BYTES-1];
  logic [7:0] cap [0:255];
  int         cap_n = 0;
  logic [15:0] model_id = '0;
  logic       last_acc = 1'b0;
  logic       in_frame = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_csum(input logic [15:0] tl, input logic [15:0] id,
                                              input logic [31:0] sip, input logic [31:0] dip);
    logic [31:0] s;
    s = 32'h4500 + 32'(tl) + 32'(id) + 32'h4000 + 32'({TTL, 8'h11})
      + 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]);
    while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
    return ~16'(s);
  endfunction

  task automatic push_frame(input int L);
    logic [335:0] hv;
    logic [15:0]  tl, ul;
    exp_t         e;
    int           n;
    tl = 16'(28 + L);
    ul = 16'(8 + L);
    hv = {i_dest_mac, i_self_mac, 16'h0800, 16'h4500, tl, model_id, 16'h4000, TTL, 8'h11,
          model_csum(tl, model_id, i_self_ip, i_dest_ip), i_self_ip, i_dest_ip,
          i_src_port, i_dest_port, ul, 16'h0000};
    n = (42 + L < 60) ? 60 : 42 + L;
    for (int k = 0; k < n; k++) begin
      if (k < 42) begin
        e.data = hv[335:328];
        hv = hv << 8;
      end else if (k < 42 + L) begin
        e.data = tb_bytes[7'(k - 42)];
      end else begin
        e.data = 8'h00;
      end
      e.last = (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_buf();
    for (int k = 0; k < int'(BUF_BYTES); k++) tb_bytes[7'(k)] = 8'($urandom());
    i_buf = '0;
    for (int k = int'(BUF_BYTES) - 1; k >= 0; k--)
      i_buf = (i_buf << 8) | BUF_SIZE'(tb_bytes[7'(k)]);
  endtask

  task automatic start_frame(input int L);
    i_length = 16'(L);
    if (L <= int'(BUF_BYTES)) push_frame(L);
    cap_n = 0;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input logic bp, input int budget);
    int c;
    c = 0;
    while (!o_done && c < budget) begin
      i_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge i_clk); #1;
      c++;
    end
    i_ready = 1'b1;
    check_val("frame_done_timeout", 32'(o_done), 32'd1);
    model_id = model_id + 16'd1;
  endtask

  // monitor: byte acceptance, stall hold, contiguous valid and done timing
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rstn) begin
      last_acc = 1'b0;
      in_frame = 1'b0;
    end else begin
      check_val("done_pulse", 32'(o_done), 32'(last_acc));
      last_acc = 1'b0;
      if (in_frame) check_val("valid_run", 32'(o_valid), 32'd1);
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_valid", 32'(o_valid), 32'd0);
        end else if (i_ready) begin
          e = exp_q.pop_front();
          check_val("data", 32'(o_data), 32'(e.data));
          check_val("last", 32'(o_last), 32'(e.last));
          cap[8'(cap_n)] = o_data;
          cap_n++;
          in_frame = !e.last;
          last_acc = e.last;
        end else begin
          check_val("stall_data", 32'(o_data), 32'(exp_q[0].data));
          check_val("stall_last", 32'(o_last), 32'(exp_q[0].last));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge i_clk);
    #1;
    check_val("rst_valid", 32'(o_valid), 32'd0);
    check_val("rst_data", 32'(o_data), 32'd0);
    check_val("rst_last", 32'(o_last), 32'd0);
    check_val("rst_busy", 32'(o_busy), 32'd0);
    check_val("rst_done", 32'(o_done), 32'd0);
    check_val("rst_len_err", 32'(o_len_err), 32'd0);
    i_rstn = 1'b1;
    @(posedge i_clk); #1;

    i_self_mac  = 48'h02_11_22_33_44_55;
    i_dest_mac  = 48'hA4_B5_C6_D7_E8_F9;
    i_self_ip   = 32'hC0A8010A;
    i_dest_ip   = 32'hC0A80101;
    i_src_port  = 16'd5000;
    i_dest_port = 16'd6000;
    model_id    = 16'd0;
    fill_buf();

    // basic frame
    start_frame(32);
    check_val("busy_after_start", 32'(o_busy), 32'd1);
    wait_done(1'b0, 400);
    check_val("f1_len", 32'(cap_n), 32'd74);
    check_val("f1_tlen_hi", 32'(cap[16]), 32'h00);
    check_val("f1_tlen_lo", 32'(cap[17]), 32'h3C);
    check_val("f1_csum_hi", 32'(cap[24]), 32'hB7);
    check_val("f1_csum_lo", 32'(cap[25]), 32'h55);
    check_val("f1_ulen_hi", 32'(cap[38]), 32'h00);
    check_val("f1_ulen_lo", 32'(cap[39]), 32'h28);
    check_val("busy_with_done", 32'(o_busy), 32'd0);

    // padded frame started in the o_done cycle
    start_frame(4);
    wait_done(1'b0, 400);
    check_val("f2_len", 32'(cap_n), 32'd60);
    for (int k = 46; k < 60; k++) check_val("f2_pad", 32'(cap[8'(k)]), 32'h00);
    check_val("f2_tlen_lo", 32'(cap[17]), 32'h20);
    check_val("f2_id_lo", 32'(cap[19]), 32'h01);
    check_val("f2_csum_hi", 32'(cap[24]), 32'hB7);
    check_val("f2_csum_lo", 32'(cap[25]), 32'h70);

    // random backpressure
    repeat (2) @(posedge i_clk);
    #1;
    fill_buf();
    start_frame(18);
    wait_done(1'b1, 2000);
    check_val("f3_len", 32'(cap_n), 32'd60);

    // length error, then maximum length
    repeat (2) @(posedge i_clk);
    #1;
    start_frame(129);
    check_val("len_err_pulse", 32'(o_len_err), 32'd1);
    check_val("len_err_valid", 32'(o_valid), 32'd0);
    @(posedge i_clk); #1;
    check_val("len_err_single", 32'(o_len_err), 32'd0);
    check_val("len_err_busy", 32'(o_busy), 32'd0);
    fill_buf();
    start_frame(128);
    wait_done(1'b0, 600);
    check_val("f4_len", 32'(cap_n), 32'd170);
    check_val("f4_last_payload", 32'(cap[169]), 32'(tb_bytes[127]));

    // start while busy is ignored
    repeat (2) @(posedge i_clk);
    #1;
    start_frame(10);
    repeat (4) @(posedge i_clk);
    #1;
    i_start    = 1'b1;
    i_length   = 16'd5;
    i_dest_mac = 48'hFF_FF_FF_FF_FF_FF;
    @(posedge i_clk); #1;
    i_start    = 1'b0;
    i_dest_mac = 48'hA4_B5_C6_D7_E8_F9;
    wait_done(1'b0, 400);
    check_val("f5_len", 32'(cap_n), 32'd60);
    repeat (30) @(posedge i_clk);
    #1;
    check_val("f5_no_second", 32'(exp_q.size()), 32'd0);
    check_val("f5_idle_valid", 32'(o_valid), 32'd0);

    // reset mid-frame at byte 20
    fill_buf();
    start_frame(20);
    c = 0;
    while (cap_n < 19 && c < 200) begin
      @(posedge i_clk); #1;
      c++;
    end
    check_val("rst_reach_byte20", 32'(cap_n), 32'd19);
    i_rstn = 1'b0;
    #1;
    check_val("rst_mid_valid", 32'(o_valid), 32'd0);
    check_val("rst_mid_busy", 32'(o_busy), 32'd0);
    exp_q.delete();
    model_id = 16'd0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    start_frame(8);
    wait_done(1'b0, 400);
    check_val("f6_len", 32'(cap_n), 32'd60);
    check_val("f6_id_hi", 32'(cap[18]), 32'h00);
    check_val("f6_id_lo", 32'(cap[19]), 32'h00);

    repeat (3) @(posedge i_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
